// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit: FSM encoding and default sizing.
package pc_redirect_unit_pkg;

  // RUN: normal fetch. PEND: a redirect is held while fetch is frozen.
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } redirect_state_t;

  localparam int XLEN_DEF     = 32;
  localparam int RESET_PC_DEF = 0;
  localparam int PC_STEP_DEF  = 4;

  // Jump/branch targets are forced to halfword alignment; bit 1 is kept so
  // a word-misaligned target can still be reported downstream.
  function automatic logic [XLEN_DEF-1:0] align_target(input logic [XLEN_DEF-1:0] t);
    return {t[XLEN_DEF-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_redirect_unit.sv
// Program-counter owner: sequential fetch, EX-stage redirects, wrong-path
// squashing, and deferral of a redirect that arrives while fetch is frozen.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(PC_STEP_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] target_addr,
  input  logic            fetch_stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            redirect_pend,
  output logic            misalign_err
);

  redirect_state_t state, next_state;
  logic [XLEN-1:0] held_target, next_held;
  logic [XLEN-1:0] next_pc;
  logic            next_misalign;
  logic            flush_ifid_raw, flush_idex_raw;

  logic            redirect;
  logic [XLEN-1:0] target_eff;

  assign redirect      = ex_valid & (branch_taken | jump);
  assign target_eff    = {target_addr[XLEN-1:1], 1'b0};
  assign pc_plus4      = pc + PC_STEP;
  assign redirect_pend = (state == PEND);

  // Flushes are combinational but must never fire while reset is applied.
  assign flush_ifid = flush_ifid_raw & ~reset;
  assign flush_idex = flush_idex_raw & ~reset;

  // Next-state, next-PC mux and flush decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    next_state     = state;
    next_pc        = pc;
    next_held      = held_target;
    next_misalign  = 1'b0;
    flush_ifid_raw = 1'b0;
    flush_idex_raw = 1'b0;

    unique case (state)
      RUN: begin
        if (redirect) begin
          flush_ifid_raw = 1'b1;
          flush_idex_raw = 1'b1;
          if (fetch_stall) begin
            next_held  = target_eff;
            next_state = PEND;
          end else begin
            next_pc       = target_eff;
            next_misalign = target_addr[1];
          end
        end else if (!fetch_stall) begin
          next_pc = pc_plus4;
        end
      end

      PEND: begin
        if (fetch_stall) begin
          // Last redirect wins while still frozen.
          if (redirect) begin
            flush_ifid_raw = 1'b1;
            flush_idex_raw = 1'b1;
            next_held      = target_eff;
          end
        end else begin
          next_state = RUN;
          if (redirect) begin
            flush_ifid_raw = 1'b1;
            flush_idex_raw = 1'b1;
            next_pc        = target_eff;
            next_misalign  = target_addr[1];
          end else begin
            // The fetch completing now came from the stale PC; ID/EX is already clean.
            flush_ifid_raw = 1'b1;
            next_pc        = held_target;
            next_misalign  = held_target[1];
          end
        end
      end

      default: next_state = RUN;
    endcase
  end

  // State, PC, held target and misalignment pulse registers; reset dominates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      held_target  <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= next_state;
      pc           <= next_pc;
      held_target  <= next_held;
      misalign_err <= next_misalign;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios followed by
// random traffic, all compared against a rule-level reference model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, branch_taken, jump, fetch_stall;
  logic [31:0] target_addr;
  logic [31:0] pc, pc_plus4;
  logic        flush_ifid, flush_idex, redirect_pend, misalign_err;

  int errors = 0;
  int checks = 0;

  // Reference model: PC value, pending redirect as a 0/1-entry queue, error pulse.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic        m_mis;

  pc_redirect_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .branch_taken (branch_taken),
    .jump         (jump),
    .target_addr  (target_addr),
    .fetch_stall  (fetch_stall),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .redirect_pend(redirect_pend),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, clock the edge, advance the model, check registered outputs.
  task automatic cycle(input logic rst, input logic ev, input logic bt, input logic jp,
                       input logic [31:0] tg, input logic st);
    logic        redir;
    logic [31:0] te;
    logic        e_fi, e_fe;
    reset = rst; ex_valid = ev; branch_taken = bt; jump = jp;
    target_addr = tg; fetch_stall = st;
    #2;
    redir = ev & (bt | jp);
    te    = {tg[31:1], 1'b0};
    e_fi  = 1'b0;
    e_fe  = 1'b0;
    if (!rst) begin
      if (redir) begin
        e_fi = 1'b1;
        e_fe = 1'b1;
      end else if (m_pend.size() != 0 && !st) begin
        e_fi = 1'b1;
      end
    end
    check("flush_ifid", 32'(flush_ifid), 32'(e_fi));
    check("flush_idex", 32'(flush_idex), 32'(e_fe));
    check("pc_plus4", pc_plus4, m_pc + 32'd4);

    // Model update from the rules, evaluated for this edge.
    m_mis = 1'b0;
    if (rst) begin
      m_pc = 32'h0;
      m_pend.delete();
    end else if (redir) begin
      if (st) begin
        m_pend.delete();
        m_pend.push_back(te);
      end else begin
        m_pc  = te;
        m_mis = tg[1];
        m_pend.delete();
      end
    end else if (m_pend.size() != 0) begin
      if (!st) begin
        m_pc  = m_pend[0];
        m_mis = m_pend[0][1];
        m_pend.delete();
      end
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end

    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("redirect_pend", 32'(redirect_pend), 32'(m_pend.size() != 0));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
  endtask

  initial begin
    m_pc  = 32'h0;
    m_mis = 1'b0;
    reset = 1'b1; ex_valid = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    target_addr = 32'h0; fetch_stall = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    cycle(1, 0, 0, 0, 32'h0, 0);
    check("reset_pc", pc, 32'h0);
    check("reset_pend", 32'(redirect_pend), 32'h0);

    // Sequential fetch 0 -> 4 -> 8 -> 12 -> 0x10.
    cycle(0, 0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("seq_pc12", pc, 32'hC);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("seq_pc10", pc, 32'h10);

    // Taken branch to 0x100, then sequential 0x104.
    cycle(0, 1, 1, 0, 32'h100, 0);
    check("branch_pc", pc, 32'h100);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("branch_seq", pc, 32'h104);

    // Branch flags ignored without ex_valid.
    cycle(0, 0, 1, 1, 32'h500, 0);
    check("invalid_ex", pc, 32'h108);

    // Jump during stall -> held; two stall cycles; release loads 0x200.
    cycle(0, 1, 0, 1, 32'h200, 1);
    check("pend_set", 32'(redirect_pend), 32'h1);
    cycle(0, 0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("pend_release", pc, 32'h200);

    // Last redirect wins while pending.
    cycle(0, 1, 0, 1, 32'h200, 1);
    cycle(0, 1, 1, 0, 32'h300, 1);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("last_wins", pc, 32'h300);

    // Redirect arriving in the release cycle beats the held one.
    cycle(0, 1, 0, 1, 32'h600, 1);
    cycle(0, 1, 0, 1, 32'h700, 0);
    check("release_redirect", pc, 32'h700);

    // Misaligned target: error pulse one cycle only; 0x201 gives no error.
    cycle(0, 1, 0, 1, 32'h203, 0);
    check("mis_pc", pc, 32'h202);
    check("mis_pulse", 32'(misalign_err), 32'h1);
    cycle(0, 0, 0, 0, 32'h0, 1);
    check("mis_clear", 32'(misalign_err), 32'h0);
    cycle(0, 1, 0, 1, 32'h201, 0);
    check("half_pc", pc, 32'h200);

    // Misaligned target delivered through the pending path.
    cycle(0, 1, 0, 1, 32'h80A, 1);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("mis_pend", 32'(misalign_err), 32'h1);

    // Reset while pending discards held target.
    cycle(0, 1, 0, 1, 32'h400, 1);
    cycle(1, 0, 0, 0, 32'h0, 1);
    check("reset_pend_pc", pc, 32'h0);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("reset_discard", pc, 32'h4);

    // Reset dominates a redirect.
    cycle(1, 1, 1, 1, 32'h900, 0);
    check("reset_dominates", pc, 32'h0);

    // Wrap-around at top of address space.
    cycle(0, 1, 1, 0, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0, 32'h0, 0);
    check("wrap", pc, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), tg, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
